window_gen: RTL and testbench
=============================

WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 Parameter IMG_W, default 28: image width in pixels, 3 or more.
REQ-002 Parameter IMG_H, default 28: image height in pixels, 3 or more.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 pix_in  input  8  raster-order pixel, row-major, unsigned.
REQ-006 pix_valid  input  1  pix_in is valid this cycle.
REQ-007 pix_ready  output  1  block accepts pix_in this cycle.
REQ-008 win_data0..win_data8  output  8 each  3x3 window, row-major: 0 = top-left, 8 = bottom-right.
REQ-009 sel  output  2  column phase 0,1,2 for the downstream multiply-select stage.
REQ-010 win_valid  output  1  window and sel are valid this cycle.
REQ-011 win_last  output  1  asserted with win_valid for the final window of a frame.
REQ-012 frame_done  output  1  one-cycle pulse after the final phase of the final window.

Function
REQ-013 A pixel is accepted when pix_valid and pix_ready are both 1 on the same cycle; no other event changes the state.
REQ-014 The block SHALL be a two-state FSM: FILL (pix_ready=1, win_valid=0) and EMIT (pix_ready=0, win_valid=1).
REQ-015 Counters: col counts 0..IMG_W-1 and row counts 0..IMG_H-1, both tracking the position of the next pixel; col wraps to 0 and row increments on each accept at col=IMG_W-1; row wraps to 0 after the accept at (IMG_H-1, IMG_W-1).
REQ-016 On accept, each line buffer (depth IMG_W): lb1[col] <= lb0[col]; lb0[col] <= pix_in.
REQ-017 On accept, the window shifts left one column; new right column = {lb1[col], lb0[col], pix_in}, read before the REQ-016 writes (top to bottom).
REQ-018 An accept with row>=2 and col>=2 SHALL move FILL->EMIT with sel=0 on the next cycle; any other accept stays in FILL.
REQ-019 In EMIT, sel advances 0->1->2 on successive cycles with the window held constant; after sel=2 the FSM returns to FILL.
REQ-020 Latency: window visible with sel=0 exactly one cycle after the completing accept; each window occupies exactly 3 cycles.
REQ-021 Window count per frame SHALL be (IMG_W-2)*(IMG_H-2), and no window may straddle a row boundary.
REQ-022 win_last=1 throughout the EMIT of the window completed by pixel (IMG_H-1, IMG_W-1); frame_done=1 on the first FILL cycle after that EMIT.
REQ-023 pix_valid gaps in FILL SHALL NOT alter counters, window, or line buffers.
REQ-024 The next frame's first pixel may be accepted in the same cycle frame_done is high; frames run back-to-back with no dead cycle.
REQ-025 sel=0 whenever win_valid=0.

Reset
REQ-026 With rst=0 at a clock edge: FSM=FILL, col=0, row=0, sel=0, win_data0..8=0, win_valid=0, win_last=0, frame_done=0; pix_ready=1 from the first cycle after reset.
REQ-027 Line buffer contents are not reset; REQ-018 gating guarantees that stale data never reaches a valid window.
REQ-028 Reset during EMIT SHALL abort the window; win_valid=0 from the next cycle.

Structure
REQ-029 Shared package cnn_pkg SHALL hold PIX_W=8, KSIZE=3, and the defaults for IMG_W and IMG_H.
REQ-030 One sub-module, line_buffer (one IMG_W x 8 synchronous-write, combinational-read array), SHALL be instantiated twice.
REQ-031 win_data0..8 and sel connect directly to the downstream convolution stage's image_data0..8 and select inputs.

Verification (IMG_W=4, IMG_H=4 unless noted)
REQ-032 Stream pixels 1..16 with pix_valid held high -> 4 windows; first window is 1,2,3,5,6,7,9,10,11; last window is 6,7,8,10,11,12,14,15,16 with win_last=1; one frame_done pulse.
REQ-033 Check each window -> sel reads 0,1,2 on consecutive cycles, pix_ready=0 for those 3 cycles, and pix_in is ignored while pix_ready=0.
REQ-034 Drop pix_valid randomly for 1-5 cycles mid-frame -> window values and count are identical to REQ-032.
REQ-035 Send two back-to-back frames, 1..16 then 101..116 -> second frame's first window is 101,102,103,105,106,107,109,110,111 and contains no first-frame data.
REQ-036 Assert rst=0 during the 2nd window's sel=1, then restart the frame -> outputs match the REQ-026 reset values, then REQ-032 is reproduced exactly.
REQ-037 With IMG_W=IMG_H=28, stream 784 pixels -> exactly 676 windows and one frame_done pulse.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants for the CNN front end: pixel width, kernel size and
// default image geometry, plus the window generator state encoding.
package cnn_pkg;

  localparam int PIX_W     = 8;
  localparam int KSIZE     = 3;
  localparam int NUM_TAPS  = KSIZE * KSIZE;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } win_state_e;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixels: synchronous write, combinational read on the same
// address so a read-before-write value is available in the write cycle.
module line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the window gating hides stale rows.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/window_gen.sv
// 3x3 sliding window generator over a raster pixel stream. Each complete
// window is presented for three cycles with sel stepping 0,1,2.
module window_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] win_data0,
  output logic [PIX_W-1:0] win_data1,
  output logic [PIX_W-1:0] win_data2,
  output logic [PIX_W-1:0] win_data3,
  output logic [PIX_W-1:0] win_data4,
  output logic [PIX_W-1:0] win_data5,
  output logic [PIX_W-1:0] win_data6,
  output logic [PIX_W-1:0] win_data7,
  output logic [PIX_W-1:0] win_data8,
  output logic [1:0]       sel,
  output logic             win_valid,
  output logic             win_last,
  output logic             frame_done,
  output logic             dbg_state
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  win_state_e       state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [1:0]       sel_q, sel_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic [PIX_W-1:0] win_q [NUM_TAPS];
  logic [PIX_W-1:0] win_d [NUM_TAPS];

  logic             accept;
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  // Handshake: a pixel transfers on a cycle where pix_valid and pix_ready are
  // both high; pix_ready is high exactly in FILL and nothing else moves state.
  assign pix_ready = (state_q == ST_FILL);
  assign accept    = pix_valid && pix_ready;

  // lb0 holds the previous row, lb1 the row before that.
  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (pix_in),
    .rdata (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sel_d   = sel_q;
    last_d  = last_q;
    done_d  = 1'b0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      win_d[i] = win_q[i];
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int r = 0; r < KSIZE; r++) begin
            win_d[r*KSIZE]     = win_q[r*KSIZE + 1];
            win_d[r*KSIZE + 1] = win_q[r*KSIZE + 2];
          end
          win_d[2] = lb1_rd;
          win_d[5] = lb0_rd;
          win_d[8] = pix_in;

          if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end

          // Only a pixel at row>=2, col>=2 closes a window lying wholly in this frame.
          if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
            state_d = ST_EMIT;
            sel_d   = 2'd0;
            last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
          end
        end
      end
      ST_EMIT: begin
        if (sel_q == 2'd2) begin
          state_d = ST_FILL;
          sel_d   = 2'd0;
          last_d  = 1'b0;
          done_d  = last_q;
        end else begin
          sel_d = sel_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_FILL;
        sel_d   = 2'd0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FILL;
      col_q   <= '0;
      row_q   <= '0;
      sel_q   <= 2'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_TAPS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign win_data0  = win_q[0];
  assign win_data1  = win_q[1];
  assign win_data2  = win_q[2];
  assign win_data3  = win_q[3];
  assign win_data4  = win_q[4];
  assign win_data5  = win_q[5];
  assign win_data6  = win_q[6];
  assign win_data7  = win_q[7];
  assign win_data8  = win_q[8];
  assign sel        = sel_q;
  assign win_valid  = (state_q == ST_EMIT);
  assign win_last   = last_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_window_gen.sv
// Bench for window_gen: a 4x4 instance driven by directed frames and checked
// through an expected-window queue, plus a 28x28 instance for window counting.
module tb_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 28;
  localparam int BH = 28;

  localparam logic [71:0] FIRST_WIN  = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
  localparam logic [71:0] LAST_WIN   = {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16};
  localparam logic [71:0] FIRST_WIN2 = {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small DUT ----------------
  logic [7:0] pix_in = 8'd0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [7:0] win_data0, win_data1, win_data2, win_data3, win_data4;
  logic [7:0] win_data5, win_data6, win_data7, win_data8;
  logic [1:0] sel;
  logic       win_valid, win_last, frame_done, dbg_state;

  window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .win_data0  (win_data0),
    .win_data1  (win_data1),
    .win_data2  (win_data2),
    .win_data3  (win_data3),
    .win_data4  (win_data4),
    .win_data5  (win_data5),
    .win_data6  (win_data6),
    .win_data7  (win_data7),
    .win_data8  (win_data8),
    .sel        (sel),
    .win_valid  (win_valid),
    .win_last   (win_last),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------- large DUT ----------------
  logic [7:0] big_pix = 8'd0;
  logic       big_valid = 1'b0;
  logic       big_ready;
  logic [7:0] bw0, bw1, bw2, bw3, bw4, bw5, bw6, bw7, bw8;
  logic [1:0] big_sel;
  logic       big_wvalid, big_last, big_done, big_state;

  window_gen #(.IMG_W(BW), .IMG_H(BH)) dut_big (
    .clk        (clk),
    .rst        (rst),
    .pix_in     (big_pix),
    .pix_valid  (big_valid),
    .pix_ready  (big_ready),
    .win_data0  (bw0),
    .win_data1  (bw1),
    .win_data2  (bw2),
    .win_data3  (bw3),
    .win_data4  (bw4),
    .win_data5  (bw5),
    .win_data6  (bw6),
    .win_data7  (bw7),
    .win_data8  (bw8),
    .sel        (big_sel),
    .win_valid  (big_wvalid),
    .win_last   (big_last),
    .frame_done (big_done),
    .dbg_state  (big_state)
  );

  // ---------------- scoreboard state ----------------
  logic [72:0] exp_q[$];
  logic [71:0] win_log[$];
  int n_checks = 0;
  int n_errors = 0;
  int win_cnt  = 0;
  int fd_cnt   = 0;
  int big_win  = 0;
  int big_fd   = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [71:0] cur_win;
  logic [71:0] held_win = '0;
  logic [72:0] e;
  logic        prev_valid = 1'b0;
  logic        prev_last  = 1'b0;
  logic [1:0]  prev_sel   = 2'd0;

  always @(negedge clk) begin
    cur_win = {win_data0, win_data1, win_data2, win_data3, win_data4,
               win_data5, win_data6, win_data7, win_data8};
    if (!rst) begin
      prev_valid = 1'b0;
      prev_sel   = 2'd0;
      prev_last  = 1'b0;
    end else if (mon_en) begin
      if (win_valid) begin
        chk("ready_low_in_emit", 72'(pix_ready), 72'd0);
        if (sel == 2'd0) begin
          win_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_window", 72'd1, 72'd0);
          end else begin
            e = exp_q.pop_front();
            chk("window_data", cur_win, e[71:0]);
            chk("win_last", 72'(win_last), 72'(e[72]));
          end
          held_win = cur_win;
          win_log.push_back(cur_win);
        end else begin
          chk("sel_step", 72'({prev_valid, sel}), 72'({1'b1, prev_sel + 2'd1}));
          chk("window_held", cur_win, held_win);
        end
      end else begin
        chk("sel_idle_zero", 72'(sel), 72'd0);
        if (prev_valid) chk("emit_three_cycles", 72'(prev_sel), 72'd2);
      end
      if (frame_done) begin
        fd_cnt++;
        chk("done_after_last", 72'({prev_valid, prev_last, prev_sel}), 72'({1'b1, 1'b1, 2'd2}));
      end
      prev_valid = win_valid;
      prev_sel   = sel;
      prev_last  = win_last;
    end
  end

  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (big_wvalid && big_sel == 2'd0) big_win++;
      if (big_done) big_fd++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int base);
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        logic [72:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            v[71 - 8*(i*3 + j) -: 8] = 8'(base + (r - 2 + i) * W + (c - 2 + j));
          end
        end
        v[72] = (r == H - 1) && (c == W - 1);
        exp_q.push_back(v);
      end
    end
  endtask

  task automatic send_pix(input logic [7:0] v);
    int budget;
    budget = 0;
    pix_valid = 1'b1;
    while (!pix_ready && budget < 20) begin
      pix_in = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      budget++;
    end
    if (!pix_ready) chk("ready_timeout", 72'd0, 72'd1);
    pix_in = v;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input int base, input bit gaps, input int npix);
    for (int k = 0; k < npix; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        pix_valid = 1'b0;
        pix_in    = 8'($urandom_range(0, 255));
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk); #1;
        end
      end
      send_pix(8'(base + k));
    end
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (fd_cnt < target && b < 40) begin
      @(posedge clk); #1;
      b++;
    end
    chk("frame_done_seen", 72'(fd_cnt), 72'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_win_data"}, {win_data0, win_data1, win_data2, win_data3, win_data4,
                             win_data5, win_data6, win_data7, win_data8}, 72'd0);
    chk({tag, "_flags"}, 72'({win_valid, win_last, frame_done, sel}), 72'd0);
    chk({tag, "_pix_ready"}, 72'(pix_ready), 72'd1);
  endtask

  task automatic run_single_frame(input string tag, input bit gaps);
    int w0, f0;
    w0 = win_cnt;
    f0 = fd_cnt;
    win_log.delete();
    push_frame(1);
    send_frame(1, gaps, W * H);
    pix_valid = 1'b0;
    wait_done(f0 + 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk({tag, "_win_count"}, 72'(win_cnt - w0), 72'd4);
    chk({tag, "_done_count"}, 72'(fd_cnt - f0), 72'd1);
    chk({tag, "_first_win"}, win_log[0], FIRST_WIN);
    chk({tag, "_last_win"}, win_log[3], LAST_WIN);
    chk({tag, "_exp_empty"}, 72'(exp_q.size()), 72'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, f0, b;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    mon_en = 1'b1;

    // Straight frame, then the same frame with random valid gaps.
    run_single_frame("plain", 1'b0);
    run_single_frame("gaps", 1'b1);

    // Two frames back to back; the second must carry no first-frame pixels.
    w0 = win_cnt;
    f0 = fd_cnt;
    win_log.delete();
    push_frame(1);
    push_frame(101);
    send_frame(1, 1'b0, W * H);
    send_frame(101, 1'b0, W * H);
    pix_valid = 1'b0;
    wait_done(f0 + 2);
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("b2b_win_count", 72'(win_cnt - w0), 72'd8);
    chk("b2b_last_of_first", win_log[3], LAST_WIN);
    chk("b2b_first_of_second", win_log[4], FIRST_WIN2);
    chk("b2b_exp_empty", 72'(exp_q.size()), 72'd0);

    // Reset while the second window shows sel=1, then replay the frame.
    win_log.delete();
    push_frame(1);
    send_frame(1, 1'b0, 12);
    @(posedge clk); #1;
    chk("sel_before_reset", 72'({win_valid, sel}), 72'({1'b1, 2'd1}));
    rst = 1'b0;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    run_single_frame("after_reset", 1'b0);

    // Full-size image: 784 pixels in, 676 windows and one frame_done out.
    w0 = big_win;
    f0 = big_fd;
    for (int k = 0; k < BW * BH; k++) begin
      big_valid = 1'b1;
      b = 0;
      while (!big_ready && b < 20) begin
        @(posedge clk); #1;
        b++;
      end
      big_pix = 8'(k);
      @(posedge clk); #1;
    end
    big_valid = 1'b0;
    b = 0;
    while (big_fd == f0 && b < 40) begin
      @(posedge clk); #1;
      b++;
    end
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("big_win_count", 72'(big_win - w0), 72'd676);
    chk("big_done_count", 72'(big_fd - f0), 72'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
